// File: rtl/fpga_top_level.sv
// Sprite-table VGA engine: host-loaded shadow registers are committed to a sprite table and drawn over 640x480 timing.
// Define FPGA_TEST_PATTERN_EN to fill uncovered visible pixels with a coordinate gradient instead of black.
module fpga_top_level #(
  parameter int unsigned NUM_SPRITES = 16
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic [7:0] hps_writedata,
  input  logic [2:0] hps_address,
  input  logic       hps_write,
  input  logic       hps_chipselect,
  output logic       vga_clk,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n
);

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] size;
    logic [7:0] xpos;
    logic [7:0] ypos;
  } sprite_t;

  localparam logic [9:0] H_VIS        = 10'd640;
  localparam logic [9:0] H_SYNC_START = 10'd656;
  localparam logic [9:0] H_SYNC_END   = 10'd752;
  localparam logic [9:0] H_LAST       = 10'd799;
  localparam logic [9:0] V_VIS        = 10'd480;
  localparam logic [9:0] V_SYNC_START = 10'd490;
  localparam logic [9:0] V_SYNC_END   = 10'd492;
  localparam logic [9:0] V_LAST       = 10'd524;

  sprite_t    shadow_q;
  sprite_t    table_q [NUM_SPRITES];

  logic       vga_clk_q;
  logic [9:0] hcount_q, vcount_q;
  logic [7:0] r_q, g_q, b_q;
  logic [7:0] r_d, g_d, b_d;
  logic       hs_q, vs_q, blank_n_q;
  logic       hs_d, vs_d, blank_n_d;

  logic        hit;
  logic [23:0] hit_rgb;
  logic [10:0] h11, v11, x0, y0, x1, y1;
  logic        active;

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      shadow_q <= '0;
      for (int unsigned i = 0; i < NUM_SPRITES; i++) table_q[i] <= '0;
    end else if (hps_write && hps_chipselect) begin
      case (hps_address)
        3'd0: shadow_q.r    <= hps_writedata;
        3'd1: shadow_q.g    <= hps_writedata;
        3'd2: shadow_q.b    <= hps_writedata;
        3'd3: shadow_q.size <= hps_writedata;
        3'd4: shadow_q.xpos <= hps_writedata;
        3'd5: shadow_q.ypos <= hps_writedata;
        3'd6: begin
          // Out-of-range indices match no entry, so the copy is dropped.
          for (int unsigned i = 0; i < NUM_SPRITES; i++)
            if (hps_writedata == 8'(i)) table_q[i] <= shadow_q;
        end
        default: ;
      endcase
    end
  end

  // Later entries overwrite earlier hits, giving the highest index priority.
  always_comb begin
    hit     = 1'b0;
    hit_rgb = '0;
    h11     = {1'b0, hcount_q};
    v11     = {1'b0, vcount_q};
    x0      = '0;
    y0      = '0;
    x1      = '0;
    y1      = '0;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      x0 = {1'b0, table_q[i].xpos, 2'b00};
      y0 = {2'b00, table_q[i].ypos, 1'b0};
      x1 = x0 + {3'b000, table_q[i].size};
      y1 = y0 + {3'b000, table_q[i].size};
      if (table_q[i].size != 8'd0 && h11 >= x0 && h11 < x1 && v11 >= y0 && v11 < y1) begin
        hit     = 1'b1;
        hit_rgb = {table_q[i].r, table_q[i].g, table_q[i].b};
      end
    end
  end

  always_comb begin
    active    = (hcount_q < H_VIS) && (vcount_q < V_VIS);
    hs_d      = !(hcount_q >= H_SYNC_START && hcount_q < H_SYNC_END);
    vs_d      = !(vcount_q >= V_SYNC_START && vcount_q < V_SYNC_END);
    blank_n_d = active;
    {r_d, g_d, b_d} = '0;
    if (active) begin
      if (hit) begin
        {r_d, g_d, b_d} = hit_rgb;
      end else begin
`ifdef FPGA_TEST_PATTERN_EN
        {r_d, g_d, b_d} = {hcount_q[7:0], vcount_q[7:0], 8'h80};
`else
        {r_d, g_d, b_d} = '0;
`endif
      end
    end
  end

  // Pixel work happens on the clk50 edge where vga_clk falls, once per pixel period.
  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      vga_clk_q <= 1'b0;
      hcount_q  <= '0;
      vcount_q  <= '0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
    end else begin
      vga_clk_q <= ~vga_clk_q;
      if (vga_clk_q) begin
        r_q       <= r_d;
        g_q       <= g_d;
        b_q       <= b_d;
        hs_q      <= hs_d;
        vs_q      <= vs_d;
        blank_n_q <= blank_n_d;
        if (hcount_q == H_LAST) begin
          hcount_q <= '0;
          vcount_q <= (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
        end else begin
          hcount_q <= hcount_q + 10'd1;
        end
      end
    end
  end

  assign vga_clk     = vga_clk_q;
  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign vga_sync_n  = 1'b0;

endmodule

// File: tb/tb_fpga_top_level.sv
// Directed bench for fpga_top_level: sync timing over two lines, sprite commit/priority, host write gating, async reset.
module tb_fpga_top_level;

  logic       clk50 = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] hps_writedata = '0;
  logic [2:0] hps_address = '0;
  logic       hps_write = 1'b0;
  logic       hps_chipselect = 1'b0;
  logic       vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n;
  logic [7:0] vga_r, vga_g, vga_b;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;

  fpga_top_level #(.NUM_SPRITES(16)) dut (
    .clk50(clk50), .reset(reset),
    .hps_writedata(hps_writedata), .hps_address(hps_address),
    .hps_write(hps_write), .hps_chipselect(hps_chipselect),
    .vga_clk(vga_clk), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n)
  );

  always #10 clk50 = ~clk50;

  // Clock edges since reset release; edge 2n+2 registers pixel n = v*800+h.
  always @(posedge clk50 or negedge reset)
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;

  initial begin
    #5ms;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
    check({tag, "_sync"}, {vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk}, 5'b11000);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk50);
    hps_address = a; hps_writedata = d; hps_write = 1'b1; hps_chipselect = 1'b1;
    @(negedge clk50);
    hps_write = 1'b0; hps_chipselect = 1'b0;
  endtask

  task automatic wr_shadow(input logic [7:0] r, g, b, s, x, y);
    wr(3'd0, r); wr(3'd1, g); wr(3'd2, b); wr(3'd3, s); wr(3'd4, x); wr(3'd5, y);
  endtask

  task automatic check_px(input string tag, input int unsigned h, v, input logic [23:0] exp);
    int unsigned target;
    target = 2 * (v * 800 + h) + 2;
    check({tag, "_sched"}, (cyc < target) ? 1 : 0, 1);
    while (cyc < target) @(negedge clk50);
    check(tag, {vga_r, vga_g, vga_b}, exp);
  endtask

  function automatic int unsigned next_line();
    return (cyc / 2) / 800 + 1;
  endfunction

  task automatic release_reset();
    @(negedge clk50);
    reset = 1'b1;
  endtask

  initial begin
    int unsigned hs_low, vs_low, blank_hi, colour_nz, clk_bad, fall1, fall2;
    logic        prev_hs;
    int unsigned v;

    repeat (3) @(negedge clk50);
    check_reset_vals("reset_hold");
    release_reset();

    hs_low = 0; vs_low = 0; blank_hi = 0; colour_nz = 0; clk_bad = 0;
    fall1 = 0; fall2 = 0; prev_hs = 1'b1;
    @(negedge clk50);
    while (cyc <= 3201) begin
      if (!vga_hs) hs_low++;
      if (!vga_vs) vs_low++;
      if (vga_blank_n) blank_hi++;
      if ({vga_r, vga_g, vga_b} != 0) colour_nz++;
      if (vga_clk !== cyc[0]) clk_bad++;
      if (prev_hs && !vga_hs) begin
        if (fall1 == 0) fall1 = cyc; else fall2 = cyc;
      end
      prev_hs = vga_hs;
      @(negedge clk50);
    end
    check("hs_low_cycles", hs_low, 384);
    check("hs_first_fall", fall1, 1314);
    check("hs_period", fall2 - fall1, 1600);
    check("vs_low_lines01", vs_low, 0);
    check("blank_hi_cycles", blank_hi, 2560);
    check("idle_colour", colour_nz, 0);
    check("vga_clk_toggle", clk_bad, 0);

    // Full-size sprite at origin.
    wr_shadow(8'hFD, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00);
    wr(3'd6, 8'd0);
    v = next_line();
    check_px("big_in", 10, v, 24'hFDFFFF);
    check_px("big_edge", 254, v, 24'hFDFFFF);
    check_px("big_out", 255, v, 24'h000000);
    check_px("hblank", 700, v, 24'h000000);

    for (int i = 0; i < 256; i++) wr(3'd6, 8'(i));
    v = next_line();
    check_px("sweep_in", 10, v, 24'hFDFFFF);
    check_px("sweep_out", 255, v, 24'h000000);

    wr(3'd3, 8'h00);
    for (int i = 0; i < 16; i++) wr(3'd6, 8'(i));
    v = next_line();
    check_px("all_disabled", 10, v, 24'h000000);

    wr_shadow(8'h22, 8'h33, 8'h44, 8'hFF, 8'h00, 8'h00);
    for (int i = 16; i < 256; i++) wr(3'd6, 8'(i));
    v = next_line();
    check_px("idx_oob_ignored", 10, v, 24'h000000);

    wr(3'd6, 8'd15);
    v = next_line();
    check_px("idx15_on", 10, v, 24'h223344);

    repeat (3) wr(3'd0, 8'hFF);
    @(negedge clk50);
    hps_address = 3'd6; hps_writedata = 8'd15; hps_write = 1'b1; hps_chipselect = 1'b0;
    @(negedge clk50);
    hps_write = 1'b0; hps_chipselect = 1'b1;
    @(negedge clk50);
    hps_chipselect = 1'b0;
    wr(3'd7, 8'd15);
    v = next_line();
    check_px("shadow_only_unchanged", 10, v, 24'h223344);

    wr(3'd3, 8'h00);
    wr(3'd6, 8'd15);
    v = next_line();
    check_px("idx15_disabled", 10, v, 24'h000000);

    // Overlapping sprites: entry 1 beats entry 0.
    @(negedge clk50);
    reset = 1'b0;
    release_reset();
    wr_shadow(8'hFF, 8'h00, 8'h00, 8'd40, 8'd0, 8'd0);
    wr(3'd6, 8'd0);
    wr_shadow(8'h00, 8'h00, 8'hFF, 8'd40, 8'd5, 8'd10);
    wr(3'd6, 8'd1);
    check_px("red_only", 10, 10, 24'hFF0000);
    check_px("red_above_blue", 30, 15, 24'hFF0000);
    check_px("overlap_blue", 30, 25, 24'h0000FF);
    check_px("blue_right_edge", 59, 25, 24'h0000FF);
    check_px("past_blue", 60, 25, 24'h000000);

    @(negedge clk50);
    #3 reset = 1'b0;
    #1 check_reset_vals("async_reset");
    release_reset();
    check_px("table_cleared", 10, 0, 24'h000000);
    check_px("table_cleared2", 10, 10, 24'h000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpga_top_level.md
FPGA_TOP_LEVEL -- requirements
Module: fpga_top_level

Interface
REQ-001 Parameter NUM_SPRITES, default 16, SHALL set the number of sprite table entries.
REQ-002 clk50  input  1  SHALL be the single 50 MHz system clock; all logic is clocked on its rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 hps_writedata  input  8  SHALL carry host write data.
REQ-005 hps_address  input  3  SHALL select the host register.
REQ-006 hps_write  input  1  SHALL be the host write strobe.
REQ-007 hps_chipselect  input  1  SHALL be the host chip select.
REQ-008 vga_clk  output  1  SHALL be the 25 MHz pixel clock.
REQ-009 vga_r, vga_g, vga_b  output  8 each  SHALL carry pixel colour.
REQ-010 vga_hs, vga_vs  output  1 each  SHALL be active-low sync pulses.
REQ-011 vga_blank_n  output  1  SHALL be high only in the visible region.
REQ-012 vga_sync_n  output  1  SHALL be tied to 0.

Function
REQ-013 A host write SHALL occur on every clk50 edge where hps_write=1 and hps_chipselect=1; no wait states.
REQ-014 Addresses 0-5 SHALL write shadow bytes: 0=R, 1=G, 2=B, 3=size, 4=xpos, 5=ypos.
REQ-015 Address 6 SHALL copy all six shadow bytes into sprite entry hps_writedata in the same cycle.
- Writedata >= NUM_SPRITES: copy ignored.
- Shadow bytes unchanged by the copy.
REQ-016 Address 7 SHALL be ignored.
REQ-017 A shadow write followed by address 6 on the next cycle SHALL commit the new value.
REQ-018 vga_clk SHALL toggle every clk50 cycle; pixel counters SHALL advance once per vga_clk period.
REQ-019 Horizontal timing SHALL be 800 pixels: 640 visible, 16 front porch, 96 sync, 48 back porch.
REQ-020 Vertical timing SHALL be 525 lines: 480 visible, 10 front porch, 2 sync, 33 back porch.
- hcount wraps 799->0.
- vcount increments on hcount wrap and wraps 524->0.
REQ-021 Sprite k SHALL cover pixel (h,v) when size!=0, xpos*4 <= h < xpos*4+size and ypos*2 <= v < ypos*2+size.
- Bounds computed at 11 bits; no wrap-around.
REQ-022 size=0 SHALL disable the entry.
REQ-023 If several sprites cover a pixel, the highest index SHALL win.
REQ-024 An uncovered visible pixel SHALL output 0,0,0.
REQ-025 Pixels outside the visible region SHALL output 0,0,0.
REQ-026 Colour, hs, vs and blank_n SHALL be registered with equal one-pixel latency relative to the counters.
REQ-027 A table write during active video SHALL take effect from the next pixel evaluated.

Reset
REQ-028 While reset=0, the block SHALL hold the following values:
- counters 0, vga_clk 0
- all shadow bytes and table entries 0 (all sprites disabled)
- vga_r/g/b 0, vga_hs 1, vga_vs 1, vga_blank_n 0
REQ-029 After reset deasserts, the first visible pixel SHALL appear at counter (0,0).
REQ-030 Reset asserted mid-frame or mid-write SHALL abort immediately with no partial commit.

Configuration
REQ-031 Macro FPGA_TEST_PATTERN_EN SHALL control uncovered visible pixels:
- Defined: output R=h[7:0], G=v[7:0], B=8'h80.
- Undefined: output black.
- Sprite pixels unaffected either way.

Verification
REQ-032 Reset, then idle one frame -> hs period 1600 clk50 cycles, hs low 192 cycles; vs low 2 lines; blank_n high 640 of every 800 pixels; colours 0.
REQ-033 Shadow writes FD,FF,FF,FF,00,00, then addr6=0 -> 255x255 region at (0,0) outputs RGB FD,FF,FF; pixel (255,0) is black.
REQ-034 Same shadow with addr6 indices 0..255 -> only entries 0..15 written, no other effect; then commit size=0 to index 15 -> entry 15 disabled.
REQ-035 Entries 0 (red, size 40, x=0,y=0) and 1 (blue, size 40, x=5,y=10) -> overlap pixel (30,25) shows blue.
REQ-036 Repeated 0xFF writes to address 0 without address 6 -> display unchanged.
REQ-037 Writes with hps_chipselect=0 or hps_write=0 -> ignored.
REQ-038 Reset pulse mid-frame -> all outputs return to reset values asynchronously.
